// File: rtl/debug_slave_pkg.sv
// Shared types and bit-position helpers for the debug slave DR engine.
// Bit positions depend on the DR width, so they are exposed as functions of it.
package debug_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_ch(input int ir_w);
        return 1 << ir_w;
    endfunction

    // Capture word: sticky overflow on top, ready (not busy) just below it
    function automatic int ovf_bit(input int dr_w);
        return dr_w - 1;
    endfunction

    function automatic int rdy_bit(input int dr_w);
        return dr_w - 2;
    endfunction

    // Command word: action request flag on top, channel-0 address load below it
    function automatic int act_bit(input int dr_w);
        return dr_w - 1;
    endfunction

    function automatic int load_bit(input int dr_w);
        return dr_w - 2;
    endfunction

endpackage

// File: rtl/debug_slave_cmd_fifo.sv
// Synchronous command queue; a push into a full queue succeeds when a pop
// happens in the same cycle. Read data is the current head entry.
module debug_slave_cmd_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic         empty_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(1'b0);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full       = (count_q == CNT_FULL);
    assign empty      = (count_q == CNT_ZERO);
    assign empty_next = (count_d == CNT_ZERO);
    assign rdata      = mem_q[rd_ptr_q];

    // Next queue contents, pointers and occupancy
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Queue storage and pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/debug_slave_dr_engine.sv
// DR shift/capture front end with a command queue and an executor that turns
// queued commands into per-channel action / no-action requests.
module debug_slave_dr_engine
    import debug_slave_pkg::*;
#(
    parameter int  IR_W       = 2,
    parameter int  DR_W       = 38,
    parameter int  ADDR_W     = 8,
    parameter int  FIFO_DEPTH = 4,
    localparam int NUM_CH     = num_ch(IR_W),
    localparam int RD_W       = DR_W - 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IR_W-1:0]        ir_in,
    input  logic                   vs_cdr,
    input  logic                   vs_sdr,
    input  logic                   vs_e1dr,
    input  logic                   tdi,
    output logic                   tdo,
    input  logic [NUM_CH*RD_W-1:0] rd_data,
    output logic [DR_W-1:0]        jdo,
    output logic [IR_W-1:0]        act_ch,
    output logic [NUM_CH-1:0]      take_action,
    output logic [NUM_CH-1:0]      take_no_action,
    input  logic                   act_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   overflow,
    output logic                   busy
);

    localparam int CW       = IR_W + DR_W;
    localparam int OVF_BIT  = ovf_bit(DR_W);
    localparam int RDY_BIT  = rdy_bit(DR_W);
    localparam int ACT_BIT  = act_bit(DR_W);
    localparam int LOAD_BIT = load_bit(DR_W);
    localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

    state_e              state_q, state_d;
    logic [DR_W-1:0]     sr_q, sr_d;
    logic                tdo_q, tdo_d;
    logic [DR_W-1:0]     jdo_q, jdo_d;
    logic [IR_W-1:0]     act_ch_q, act_ch_d;
    logic [NUM_CH-1:0]   take_action_q, take_action_d;
    logic [NUM_CH-1:0]   take_no_action_q, take_no_action_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, busy_d;
    logic                push_s, pop_s, drop_s;
    logic                fifo_full_s, fifo_empty_s, fifo_empty_next_s;
    logic [CW-1:0]       fifo_rdata_s;

    debug_slave_cmd_fifo #(
        .W     (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .pop        (pop_s),
        .wdata      ({ir_in, sr_q}),
        .rdata      (fifo_rdata_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .empty_next (fifo_empty_next_s)
    );

    // Shift register, capture mux, enqueue and sticky overflow
    always_comb begin
        sr_d   = sr_q;
        push_s = vs_e1dr & ~vs_cdr;
        if (vs_cdr) begin
            sr_d[OVF_BIT]  = overflow_q;
            sr_d[RDY_BIT]  = ~busy_q;
            sr_d[RD_W-1:0] = rd_data[int'(ir_in)*RD_W +: RD_W];
        end else if (vs_e1dr) begin
            sr_d = sr_q;
        end else if (vs_sdr) begin
            sr_d = {tdi, sr_q[DR_W-1:1]};
        end else begin
            sr_d = sr_q;
        end
        tdo_d      = sr_d[0];
        drop_s     = push_s & fifo_full_s & ~pop_s;
        overflow_d = (overflow_q & ~vs_cdr) | drop_s;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) state_d = EXEC;
                else               state_d = IDLE;
            end
            EXEC: begin
                if (act_ready) state_d = DONE;
                else           state_d = EXEC;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pop, command latch, address channel, requests, busy
    always_comb begin
        pop_s            = 1'b0;
        jdo_d            = jdo_q;
        act_ch_d         = act_ch_q;
        take_action_d    = {NUM_CH{1'b0}};
        take_no_action_d = {NUM_CH{1'b0}};
        if (state_q == IDLE && !fifo_empty_s) begin
            pop_s    = 1'b1;
            act_ch_d = fifo_rdata_s[CW-1:DR_W];
            jdo_d    = fifo_rdata_s[DR_W-1:0];
        end else begin
            pop_s = 1'b0;
        end
        // A load takes effect as the command enters EXEC and suppresses its increment
        if (pop_s && fifo_rdata_s[CW-1:DR_W] == {IR_W{1'b0}} && fifo_rdata_s[LOAD_BIT]) begin
            mem_addr_d = fifo_rdata_s[ADDR_W-1:0];
        end else if (state_q == EXEC && act_ready && act_ch_q == {IR_W{1'b0}}
                     && jdo_q[ACT_BIT] && !jdo_q[LOAD_BIT]) begin
            mem_addr_d = mem_addr_q + ADDR_ONE;
        end else begin
            mem_addr_d = mem_addr_q;
        end
        if (state_d == EXEC) begin
            if (jdo_d[ACT_BIT]) take_action_d = CH_ONE << act_ch_d;
            else                take_no_action_d = CH_ONE << act_ch_d;
        end else begin
            take_action_d    = {NUM_CH{1'b0}};
            take_no_action_d = {NUM_CH{1'b0}};
        end
        busy_d = !fifo_empty_next_s || (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q             <= {DR_W{1'b0}};
            tdo_q            <= 1'b0;
            jdo_q            <= {DR_W{1'b0}};
            act_ch_q         <= {IR_W{1'b0}};
            take_action_q    <= {NUM_CH{1'b0}};
            take_no_action_q <= {NUM_CH{1'b0}};
            mem_addr_q       <= {ADDR_W{1'b0}};
            overflow_q       <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            sr_q             <= sr_d;
            tdo_q            <= tdo_d;
            jdo_q            <= jdo_d;
            act_ch_q         <= act_ch_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            mem_addr_q       <= mem_addr_d;
            overflow_q       <= overflow_d;
            busy_q           <= busy_d;
        end
    end

    assign tdo            = tdo_q;
    assign jdo            = jdo_q;
    assign act_ch         = act_ch_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign mem_addr       = mem_addr_q;
    assign overflow       = overflow_q;
    assign busy           = busy_q;

endmodule
